// File: rtl/pc_ctrl_if.sv
// Bus between the control FSM / datapath and the program-counter unit.
// Branch-statistics counters exist only when PC_BRANCH_STATS_EN is defined.
interface pc_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             PCWrite;
    logic             PCWriteCond;
    logic [1:0]       BranchType;
    logic             zero;
    logic             neg;
    logic [1:0]       PCSource;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] ALUOut;
    logic [WIDTH-1:0] rs_data;
    logic [25:0]      IR_low26;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] PCvalue;
    logic [WIDTH-1:0] EPC;
    logic             in_exc;
    logic             addr_err;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0]      br_taken_cnt;
    logic [15:0]      br_nt_cnt;
`endif

    modport master (
        output PCWrite, PCWriteCond, BranchType, zero, neg, PCSource,
        output result, ALUOut, rs_data, IR_low26, exc_req, eret,
        input  PCvalue, EPC, in_exc, addr_err
`ifdef PC_BRANCH_STATS_EN
        , input br_taken_cnt, br_nt_cnt
`endif
    );

    modport slave (
        input  PCWrite, PCWriteCond, BranchType, zero, neg, PCSource,
        input  result, ALUOut, rs_data, IR_low26, exc_req, eret,
        output PCvalue, EPC, in_exc, addr_err
`ifdef PC_BRANCH_STATS_EN
        , output br_taken_cnt, br_nt_cnt
`endif
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter unit: next-PC select, branch conditions, alignment trap, exception entry/eret.
// Optional branch taken/not-taken counters enabled by PC_BRANCH_STATS_EN.
module pc_ctrl #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h180)
) (
    input  logic      clk,
    input  logic      rst,
    pc_ctrl_if.slave  bus
);
    localparam int unsigned JT_LSB = 28;
    localparam int unsigned CNT_W  = 16;

    logic             cond_c;
    logic             take_c;
    logic             wr_c;
    logic             misalign_c;
    logic             exc_take_c;
    logic             eret_take_c;
    logic [WIDTH-1:0] jtarget_c;
    logic [WIDTH-1:0] target_c;

    // J-target keeps the current PC region above bit 27; none exists at WIDTH==28
    generate
        if (WIDTH > JT_LSB) begin : g_jt_region
            assign jtarget_c = {bus.PCvalue[WIDTH-1:JT_LSB], bus.IR_low26, 2'b00};
        end else begin : g_jt_flat
            assign jtarget_c = {bus.IR_low26, 2'b00};
        end
    endgenerate

    // Branch condition, target select and event classification
    always_comb begin
        cond_c   = 1'b0;
        target_c = bus.result;
        case (bus.BranchType)
            2'b00:   cond_c = bus.zero;
            2'b01:   cond_c = ~bus.zero;
            2'b10:   cond_c = bus.neg;
            default: cond_c = ~bus.neg;
        endcase
        take_c = bus.PCWriteCond & cond_c;
        case (bus.PCSource)
            2'b01:   target_c = bus.ALUOut;
            2'b10:   target_c = jtarget_c;
            2'b11:   target_c = bus.rs_data;
            default: target_c = bus.result;
        endcase
        if (take_c) begin
            target_c = bus.ALUOut;
        end
        wr_c        = take_c | bus.PCWrite;
        misalign_c  = wr_c & (target_c[1:0] != 2'b00);
        exc_take_c  = bus.exc_req & ~bus.in_exc;
        eret_take_c = bus.eret & bus.in_exc & ~exc_take_c;
    end

    // PC / EPC / exception-state registers, highest-priority event first
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.PCvalue  <= RESET_VEC;
            bus.EPC      <= '0;
            bus.in_exc   <= 1'b0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.addr_err <= 1'b0;
            if (exc_take_c) begin
                bus.PCvalue <= EXC_VEC;
                bus.EPC     <= bus.PCvalue;
                bus.in_exc  <= 1'b1;
            end else if (eret_take_c) begin
                bus.PCvalue <= bus.EPC;
                bus.in_exc  <= 1'b0;
            end else if (misalign_c) begin
                bus.addr_err <= 1'b1;
                // Already in a handler: drop the write, only flag the fault
                if (!bus.in_exc) begin
                    bus.PCvalue <= EXC_VEC;
                    bus.EPC     <= bus.PCvalue;
                    bus.in_exc  <= 1'b1;
                end
            end else if (wr_c) begin
                bus.PCvalue <= target_c;
            end
        end
    end

`ifdef PC_BRANCH_STATS_EN
    logic count_c;

    assign count_c = bus.PCWriteCond & ~exc_take_c & ~eret_take_c;

    // Saturating branch statistics; a trapped misaligned branch still counts by its condition
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.br_taken_cnt <= '0;
            bus.br_nt_cnt    <= '0;
        end else if (count_c) begin
            if (cond_c) begin
                if (bus.br_taken_cnt != {CNT_W{1'b1}}) begin
                    bus.br_taken_cnt <= bus.br_taken_cnt + CNT_W'(1);
                end
            end else begin
                if (bus.br_nt_cnt != {CNT_W{1'b1}}) begin
                    bus.br_nt_cnt <= bus.br_nt_cnt + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
